// File: rtl/pipeline_pkg.sv
// Shared definitions for the 5-stage ARM-subset pipeline: address/data widths,
// PC increment, fetch-stage state encodings and the NOP instruction word.
package pipeline_pkg;

    localparam int AW     = 8;
    localparam int DW     = 32;
    localparam int PC_INC = 4;
    localparam int CW     = 16;

    localparam logic [31:0] NOP_INSTR = 32'h0000_0000;

    // Action taken by the fetch stage at the last clock edge.
    typedef enum logic [1:0] {
        FETCH_RUN   = 2'b00,
        FETCH_STALL = 2'b01,
        FETCH_FLUSH = 2'b10
    } fetch_state_t;

    // Branch targets must be word aligned; the two low bits are dropped.
    function automatic logic [AW-1:0] align_word(input logic [AW-1:0] addr);
        return {addr[AW-1:2], 2'b00};
    endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter: increments on inc, sticks at all-ones, synchronous
// active-low clear.
module sat_counter #(
    parameter int CW = 16
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          inc,
    output logic [CW-1:0] count
);

    // Count up on request, never wrap past the maximum value.
    always_ff @(posedge clk) begin
        if (!reset) begin
            count <= '0;
        end else if (inc && (count != {CW{1'b1}})) begin
            count <= count + {{(CW-1){1'b0}}, 1'b1};
        end
    end

endmodule

// File: rtl/fetch_stage.sv
// Instruction-fetch stage with IF/ID pipeline register.
// Owns the PC (drives the combinational ROM), captures {instruction, pc, pc+4}
// into IF/ID, obeys hazard stall enables and branch redirects, and keeps
// fetch / bubble performance counters.
//
// Flow control: there is no valid/ready pair here. enable_ifid acts as the
// downstream "ready" (0 = decode cannot accept, IF/ID and PC both hold so no
// fetch is lost); enable_pc gates only the PC (0 with enable_ifid=1 inserts a
// NOP bubble). ifid_valid is the "valid" qualifier of what sits in IF/ID.
// branch_taken overrides both enables and flushes IF/ID.
module fetch_stage #(
    parameter int AW     = pipeline_pkg::AW,
    parameter int DW     = pipeline_pkg::DW,
    parameter int PC_INC = pipeline_pkg::PC_INC,
    parameter int CW     = pipeline_pkg::CW
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          enable_pc,
    input  logic          enable_ifid,
    input  logic          branch_taken,
    input  logic [AW-1:0] branch_target,
    input  logic [DW-1:0] rom_instruction,
    output logic [AW-1:0] pc,
    output logic [DW-1:0] ifid_instruction,
    output logic [AW-1:0] ifid_pc,
    output logic [AW-1:0] ifid_pc_plus4,
    output logic          ifid_valid,
    output logic [1:0]    fetch_state,
    output logic [CW-1:0] fetch_count,
    output logic [CW-1:0] bubble_count
);

    import pipeline_pkg::*;

    localparam logic [AW-1:0] PC_STEP = AW'(PC_INC);
    localparam logic [DW-1:0] NOP_WORD = DW'(NOP_INSTR);

    fetch_state_t  state_q;
    logic [AW-1:0] pc_next_seq;
    logic [AW-1:0] target_aligned;

    // Per-edge action, mutually exclusive, in priority order.
    logic act_flush;
    logic act_hold;
    logic act_bubble;
    logic act_fetch;

    assign pc_next_seq    = pc + PC_STEP;
    assign target_aligned = {branch_target[AW-1:2], 2'b00};

    // Decode which of the four actions applies this cycle (first match wins).
    always_comb begin
        act_flush  = 1'b0;
        act_hold   = 1'b0;
        act_bubble = 1'b0;
        act_fetch  = 1'b0;
        if (branch_taken) begin
            act_flush = 1'b1;
        end else if (!enable_ifid) begin
            act_hold = 1'b1;
        end else if (!enable_pc) begin
            act_bubble = 1'b1;
        end else begin
            act_fetch = 1'b1;
        end
    end

    // PC register, IF/ID register and fetch state, all updated together.
    always_ff @(posedge clk) begin
        if (!reset) begin
            pc               <= '0;
            ifid_instruction <= NOP_WORD;
            ifid_pc          <= '0;
            ifid_pc_plus4    <= '0;
            ifid_valid       <= 1'b0;
            state_q          <= FETCH_RUN;
        end else if (act_flush) begin
            pc               <= target_aligned;
            ifid_instruction <= NOP_WORD;
            ifid_pc          <= '0;
            ifid_pc_plus4    <= '0;
            ifid_valid       <= 1'b0;
            state_q          <= FETCH_FLUSH;
        end else if (act_hold) begin
            state_q          <= FETCH_STALL;
        end else if (act_bubble) begin
            ifid_instruction <= NOP_WORD;
            ifid_pc          <= '0;
            ifid_pc_plus4    <= '0;
            ifid_valid       <= 1'b0;
            state_q          <= FETCH_STALL;
        end else begin
            pc               <= pc_next_seq;
            ifid_instruction <= rom_instruction;
            ifid_pc          <= pc;
            ifid_pc_plus4    <= pc_next_seq;
            ifid_valid       <= 1'b1;
            state_q          <= FETCH_RUN;
        end
    end

    assign fetch_state = state_q;

    sat_counter #(.CW(CW)) u_fetch_count (
        .clk   (clk),
        .reset (reset),
        .inc   (act_fetch),
        .count (fetch_count)
    );

    sat_counter #(.CW(CW)) u_bubble_count (
        .clk   (clk),
        .reset (reset),
        .inc   (act_flush | act_bubble),
        .count (bubble_count)
    );

endmodule

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage: directed scenarios plus randomized
// stimulus against a behavioural model of the fetch rules.
module tb_fetch_stage;

    localparam int AW = 8;
    localparam int DW = 32;
    localparam int CW = 6;
    localparam int CNT_MAX = (1 << CW) - 1;

    logic          clk;
    logic          reset;
    logic          enable_pc;
    logic          enable_ifid;
    logic          branch_taken;
    logic [AW-1:0] branch_target;
    logic [DW-1:0] rom_instruction;
    logic [AW-1:0] pc;
    logic [DW-1:0] ifid_instruction;
    logic [AW-1:0] ifid_pc;
    logic [AW-1:0] ifid_pc_plus4;
    logic          ifid_valid;
    logic [1:0]    fetch_state;
    logic [CW-1:0] fetch_count;
    logic [CW-1:0] bubble_count;

    int checks;
    int failures;

    // Combinational ROM, 64 words, word-indexed by the DUT's pc.
    logic [DW-1:0] rom [0:63];
    assign rom_instruction = rom[pc[7:2]];

    // Reference model state (plain integers).
    int m_pc, m_ipc, m_ipc4, m_fc, m_bc, m_state;
    logic [DW-1:0] m_instr;
    logic m_valid;

    fetch_stage #(.AW(AW), .DW(DW), .PC_INC(4), .CW(CW)) dut (
        .clk              (clk),
        .reset            (reset),
        .enable_pc        (enable_pc),
        .enable_ifid      (enable_ifid),
        .branch_taken     (branch_taken),
        .branch_target    (branch_target),
        .rom_instruction  (rom_instruction),
        .pc               (pc),
        .ifid_instruction (ifid_instruction),
        .ifid_pc          (ifid_pc),
        .ifid_pc_plus4    (ifid_pc_plus4),
        .ifid_valid       (ifid_valid),
        .fetch_state      (fetch_state),
        .fetch_count      (fetch_count),
        .bubble_count     (bubble_count)
    );

    // Clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Model of one clock edge, written from the fetch rules.
    function automatic void model_edge();
        if (!reset) begin
            m_pc = 0; m_instr = '0; m_ipc = 0; m_ipc4 = 0; m_valid = 0;
            m_state = 0; m_fc = 0; m_bc = 0;
        end else if (branch_taken) begin
            m_pc = (branch_target / 4) * 4;
            m_instr = '0; m_ipc = 0; m_ipc4 = 0; m_valid = 0;
            m_state = 2;
            if (m_bc < CNT_MAX) m_bc++;
        end else if (!enable_ifid) begin
            m_state = 1;
        end else if (!enable_pc) begin
            m_instr = '0; m_ipc = 0; m_ipc4 = 0; m_valid = 0;
            m_state = 1;
            if (m_bc < CNT_MAX) m_bc++;
        end else begin
            m_instr = rom[m_pc / 4];
            m_ipc   = m_pc;
            m_ipc4  = (m_pc + 4) % 256;
            m_pc    = (m_pc + 4) % 256;
            m_valid = 1;
            m_state = 0;
            if (m_fc < CNT_MAX) m_fc++;
        end
    endfunction

    // Driver: apply current inputs across one rising edge, settle past it.
    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic drive(input logic rst, input logic epc, input logic eifid,
                         input logic br, input logic [AW-1:0] tgt);
        reset = rst; enable_pc = epc; enable_ifid = eifid;
        branch_taken = br; branch_target = tgt;
    endtask

    task automatic test_reset();
        drive(1'b0, 1'b1, 1'b1, 1'b0, 8'h00);
        step(); step();
        checks++; if (pc !== 8'd0) begin failures++; $display("FAIL reset_pc got=%0d exp=0", pc); end
        checks++; if (ifid_instruction !== 32'd0 || ifid_valid !== 1'b0) begin failures++; $display("FAIL reset_ifid got=%h/%b exp=0/0", ifid_instruction, ifid_valid); end
        checks++; if (fetch_state !== 2'b00 || fetch_count !== '0 || bubble_count !== '0) begin failures++; $display("FAIL reset_state_cnt got=%b/%0d/%0d exp=00/0/0", fetch_state, fetch_count, bubble_count); end
    endtask

    task automatic test_sequential_fetch();
        drive(1'b1, 1'b1, 1'b1, 1'b0, 8'h00);
        step();
        checks++; if (pc !== 8'd4 || ifid_instruction !== rom[0] || ifid_pc_plus4 !== 8'd4) begin failures++; $display("FAIL fetch1 got pc=%0d instr=%h pc4=%0d exp 4/%h/4", pc, ifid_instruction, ifid_pc_plus4, rom[0]); end
        step();
        checks++; if (pc !== 8'd8 || ifid_instruction !== rom[1] || ifid_pc_plus4 !== 8'd8 || ifid_valid !== 1'b1) begin failures++; $display("FAIL fetch2 got pc=%0d instr=%h pc4=%0d v=%b exp 8/%h/8/1", pc, ifid_instruction, ifid_pc_plus4, ifid_valid, rom[1]); end
        checks++; if (fetch_count !== CW'(2)) begin failures++; $display("FAIL fetch_count got=%0d exp=2", fetch_count); end
    endtask

    task automatic test_bubble_stall();
        drive(1'b1, 1'b0, 1'b1, 1'b0, 8'h00);
        for (int i = 0; i < 2; i++) begin
            step();
            checks++; if (pc !== 8'd8 || ifid_valid !== 1'b0 || ifid_instruction !== 32'd0) begin failures++; $display("FAIL bubble%0d got pc=%0d v=%b instr=%h exp 8/0/0", i, pc, ifid_valid, ifid_instruction); end
        end
        checks++; if (bubble_count !== CW'(2) || fetch_state !== 2'b01) begin failures++; $display("FAIL bubble_cnt_state got=%0d/%b exp=2/01", bubble_count, fetch_state); end
        drive(1'b1, 1'b1, 1'b1, 1'b0, 8'h00);
        step();
        checks++; if (ifid_instruction !== rom[2] || ifid_pc !== 8'd8 || pc !== 8'd12) begin failures++; $display("FAIL bubble_resume got instr=%h ipc=%0d pc=%0d exp %h/8/12", ifid_instruction, ifid_pc, pc, rom[2]); end
    endtask

    task automatic test_ifid_hold();
        drive(1'b1, 1'b1, 1'b0, 1'b0, 8'h00);
        step();
        checks++; if (pc !== 8'd12 || ifid_instruction !== rom[2] || ifid_pc !== 8'd8 || ifid_valid !== 1'b1) begin failures++; $display("FAIL hold_regs got pc=%0d instr=%h ipc=%0d exp 12/%h/8", pc, ifid_instruction, ifid_pc, rom[2]); end
        checks++; if (fetch_count !== CW'(3) || bubble_count !== CW'(2) || fetch_state !== 2'b01) begin failures++; $display("FAIL hold_counts got=%0d/%0d/%b exp=3/2/01", fetch_count, bubble_count, fetch_state); end
        drive(1'b1, 1'b1, 1'b1, 1'b0, 8'h00);
        step();
        checks++; if (ifid_instruction !== rom[3] || ifid_pc !== 8'd12 || pc !== 8'd16) begin failures++; $display("FAIL hold_resume got instr=%h ipc=%0d pc=%0d exp %h/12/16", ifid_instruction, ifid_pc, pc, rom[3]); end
    endtask

    task automatic test_branch_flush();
        drive(1'b1, 1'b0, 1'b1, 1'b1, 8'h40);
        step();
        checks++; if (pc !== 8'h40 || ifid_instruction !== 32'd0 || ifid_valid !== 1'b0 || fetch_state !== 2'b10) begin failures++; $display("FAIL flush got pc=%h instr=%h v=%b st=%b exp 40/0/0/10", pc, ifid_instruction, ifid_valid, fetch_state); end
        checks++; if (bubble_count !== CW'(3)) begin failures++; $display("FAIL flush_bubble got=%0d exp=3", bubble_count); end
        drive(1'b1, 1'b1, 1'b1, 1'b0, 8'h00);
        step();
        checks++; if (ifid_instruction !== rom[16] || ifid_pc !== 8'h40 || fetch_state !== 2'b00) begin failures++; $display("FAIL after_flush got instr=%h ipc=%h st=%b exp %h/40/00", ifid_instruction, ifid_pc, fetch_state, rom[16]); end
        step();
        checks++; if (ifid_instruction !== 32'd0 || ifid_valid !== 1'b1) begin failures++; $display("FAIL zero_word got instr=%h v=%b exp 0/1", ifid_instruction, ifid_valid); end
    endtask

    task automatic test_wrap_and_align();
        drive(1'b1, 1'b1, 1'b1, 1'b1, 8'hFC);
        step();
        drive(1'b1, 1'b1, 1'b1, 1'b0, 8'h00);
        step();
        checks++; if (pc !== 8'd0 || ifid_pc !== 8'd252 || ifid_pc_plus4 !== 8'd0) begin failures++; $display("FAIL wrap got pc=%0d ipc=%0d pc4=%0d exp 0/252/0", pc, ifid_pc, ifid_pc_plus4); end
        drive(1'b1, 1'b1, 1'b1, 1'b1, 8'h43);
        step();
        checks++; if (pc !== 8'h40) begin failures++; $display("FAIL align got pc=%h exp=40", pc); end
    endtask

    task automatic test_mid_run_reset();
        drive(1'b1, 1'b1, 1'b1, 1'b0, 8'h00);
        step(); step();
        drive(1'b0, 1'b1, 1'b1, 1'b1, 8'h80);
        step();
        checks++; if (pc !== 8'd0 || ifid_instruction !== 32'd0 || ifid_pc !== 8'd0 || ifid_pc_plus4 !== 8'd0 || ifid_valid !== 1'b0) begin failures++; $display("FAIL midreset_regs got pc=%h instr=%h ipc=%h pc4=%h v=%b exp zeros", pc, ifid_instruction, ifid_pc, ifid_pc_plus4, ifid_valid); end
        checks++; if (fetch_state !== 2'b00 || fetch_count !== '0 || bubble_count !== '0) begin failures++; $display("FAIL midreset_cnt got=%b/%0d/%0d exp=00/0/0", fetch_state, fetch_count, bubble_count); end
    endtask

    task automatic test_random();
        for (int i = 0; i < 300; i++) begin
            drive(($urandom_range(0, 49) != 0), ($urandom_range(0, 3) != 0),
                  ($urandom_range(0, 4) != 0), ($urandom_range(0, 9) == 0),
                  8'($urandom_range(0, 255)));
            step();
            checks++;
            if (pc !== AW'(m_pc) || ifid_instruction !== m_instr || ifid_pc !== AW'(m_ipc) ||
                ifid_pc_plus4 !== AW'(m_ipc4) || ifid_valid !== m_valid || fetch_state !== 2'(m_state) ||
                fetch_count !== CW'(m_fc) || bubble_count !== CW'(m_bc)) begin
                failures++;
                $display("FAIL random[%0d] got pc=%h ins=%h ipc=%h pc4=%h v=%b st=%b fc=%0d bc=%0d exp %h %h %h %h %b %0d %0d %0d",
                         i, pc, ifid_instruction, ifid_pc, ifid_pc_plus4, ifid_valid, fetch_state, fetch_count, bubble_count,
                         m_pc, m_instr, m_ipc, m_ipc4, m_valid, m_state, m_fc, m_bc);
            end
        end
    endtask

    task automatic test_saturation();
        drive(1'b0, 1'b1, 1'b1, 1'b0, 8'h00);
        step();
        drive(1'b1, 1'b1, 1'b1, 1'b0, 8'h00);
        for (int i = 0; i < CNT_MAX + 10; i++) step();
        checks++; if (fetch_count !== CW'(CNT_MAX) || CW'(m_fc) !== fetch_count) begin failures++; $display("FAIL sat_fetch got=%0d exp=%0d", fetch_count, CNT_MAX); end
        drive(1'b1, 1'b0, 1'b1, 1'b0, 8'h00);
        for (int i = 0; i < CNT_MAX + 10; i++) step();
        checks++; if (bubble_count !== CW'(CNT_MAX) || fetch_count !== CW'(CNT_MAX)) begin failures++; $display("FAIL sat_bubble got=%0d/%0d exp=%0d/%0d", bubble_count, fetch_count, CNT_MAX, CNT_MAX); end
    endtask

    initial begin
        checks = 0; failures = 0;
        for (int i = 0; i < 64; i++) rom[i] = $urandom() | 32'h1;
        rom[17] = 32'd0;
        drive(1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
        m_pc = 0; m_instr = '0; m_ipc = 0; m_ipc4 = 0; m_valid = 0;
        m_state = 0; m_fc = 0; m_bc = 0;
        test_reset();
        test_sequential_fetch();
        test_bubble_stall();
        test_ifid_hold();
        test_branch_flush();
        test_wrap_and_align();
        test_mid_run_reset();
        test_random();
        test_saturation();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
